// File: rtl/alu4_seg_driver.sv
// 4-bit ALU with registered result/flags (1 cycle) plus a 4-digit multiplexed 7-segment scanner.
// No backpressure; the display latches a frame snapshot so mid-frame input changes are deferred.
module alu4_seg_driver #(
  parameter int REFRESH_DIV    = 50_000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [2:0] SEL,
  output logic [4:0] RESULT,
  output logic       CARRY,
  output logic       ZERO,
  output logic       NEG,
  output logic [3:0] AN,
  output logic [6:0] SEG,
  output logic       DP
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] r;
    logic       neg;
  } snap_t;

  logic [4:0]    alu_res;
  logic          alu_neg;
  logic [4:0]    result_q;
  logic          zero_q;
  logic          neg_q;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          first_q;
  logic          wrap;
  snap_t         snap;
  snap_t         live;
  snap_t         view;
  logic [3:0]    nibble;
  logic [6:0]    seg_lit;
  logic          dp_lit;
  logic [3:0]    an_oh;

  function automatic logic [6:0] hex_font(input logic [3:0] d);
    logic [6:0] f;
    case (d)
      4'h0: f = 7'h3F;
      4'h1: f = 7'h06;
      4'h2: f = 7'h5B;
      4'h3: f = 7'h4F;
      4'h4: f = 7'h66;
      4'h5: f = 7'h6D;
      4'h6: f = 7'h7D;
      4'h7: f = 7'h07;
      4'h8: f = 7'h7F;
      4'h9: f = 7'h6F;
      4'hA: f = 7'h77;
      4'hB: f = 7'h7C;
      4'hC: f = 7'h39;
      4'hD: f = 7'h5E;
      4'hE: f = 7'h79;
      default: f = 7'h71;
    endcase
    return f;
  endfunction

  always_comb begin
    alu_res = '0;
    case (SEL)
      3'b000:  alu_res = {1'b0, A} + {1'b0, B};
      3'b001:  alu_res = {A < B, A - B};
      3'b010:  alu_res = {1'b0, A & B};
      3'b011:  alu_res = {1'b0, A | B};
      3'b100:  alu_res = {1'b0, A ^ B};
      3'b101:  alu_res = {1'b0, ~A};
      3'b110:  alu_res = {A[3], A[2:0], 1'b0};
      default: alu_res = {A[0], 1'b0, A[3:1]};
    endcase
    alu_neg = (SEL == 3'b001) && (A < B);
  end

  // Snapshot takes the result being registered this edge, so digits always match the shown A/B.
  assign live = '{a: A, b: B, r: alu_res, neg: alu_neg};
  assign wrap = (cnt == CNT_MAX) && (idx == 2'd3);
  // On the very first cycle the snapshot is still loading, so display straight from the inputs.
  assign view = first_q ? live : snap;

  always_comb begin
    nibble = view.r[3:0];
    dp_lit = 1'b0;
    case (idx)
      2'd0: begin
        nibble = view.r[3:0];
        dp_lit = view.neg;
      end
      2'd1:    nibble = {3'b000, view.r[4]};
      2'd2:    nibble = view.b;
      default: nibble = view.a;
    endcase
    seg_lit = hex_font(nibble);
    an_oh   = 4'b0001 << idx;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      cnt      <= '0;
      idx      <= 2'd0;
      first_q  <= 1'b1;
      snap     <= '0;
      AN       <= AN_OFF;
      SEG      <= SEG_OFF;
      DP       <= SEG_ACTIVE_LOW;
    end else begin
      result_q <= alu_res;
      zero_q   <= (alu_res[3:0] == 4'h0);
      neg_q    <= alu_neg;
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (first_q || wrap) snap <= live;
      first_q  <= 1'b0;
      AN       <= AN_ACTIVE_LOW ? ~an_oh : an_oh;
      SEG      <= SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
      DP       <= SEG_ACTIVE_LOW ? ~dp_lit : dp_lit;
    end
  end

  assign RESULT = result_q;
  assign CARRY  = result_q[4];
  assign ZERO   = zero_q;
  assign NEG    = neg_q;

endmodule
